oled_cmd_sequencer: RTL and testbench

// - Upstream feeder of the OLED I2C byte-write driver: one driver transaction = {slave addr, control byte, 1 payload byte}.
// - After reset: waits for panel power-up, plays the SSD1306 128x64 init table, then optionally clears GDDRAM.
// - Then hands the link to the text renderer: host command/data bytes pass through with a valid/ready handshake.

---
 rtl/oled_pkg.sv | 52 +++++
 rtl/oled_init_rom.sv | 51 +++++
 rtl/oled_cmd_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_oled_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// ----------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the SSD1306 OLED command sequencer:
//   - I2C control bytes that prefix every payload (command vs. GDDRAM data)
//   - page / column addressing commands used to clear the panel
//   - panel geometry (8 pages x 128 columns) and init table length
//   - sequencer state encoding and clear sub-phase encoding
// No ports (package).
// ----------------------------------------------------------------------------
package oled_pkg;

  localparam logic [7:0] CTRL_CMD      = 8'h00;
  localparam logic [7:0] CTRL_DATA     = 8'h40;

  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO    = 8'h00;
  localparam logic [7:0] CMD_COL_HI    = 8'h10;

  localparam int unsigned NUM_PAGES    = 8;
  localparam int unsigned NUM_COLS     = 128;
  localparam int unsigned INIT_ROM_LEN = 25;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_INIT  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_READY = 3'd3,
    ST_ISSUE = 3'd4,
    ST_WAIT  = 3'd5,
    ST_GAP   = 3'd6,
    ST_ERROR = 3'd7
  } seq_state_t;

  // Within one page: three addressing commands, then the data run.
  typedef enum logic [1:0] {
    CLR_PAGE   = 2'd0,
    CLR_COL_LO = 2'd1,
    CLR_COL_HI = 2'd2,
    CLR_DATA   = 2'd3
  } clr_phase_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/oled_init_rom.sv
// ----------------------------------------------------------------------------
// oled_init_rom
// Combinational SSD1306 128x64 power-on init table.
// Ports:
//   idx      in   5  table index (0 .. INIT_ROM_LEN-1)
//   rom_byte out  8  command byte at idx (NOP 8'hE3 beyond the table)
//   last_idx out  5  index of the final table entry (table length - 1)
// ----------------------------------------------------------------------------
module oled_init_rom
  import oled_pkg::*;
(
  input  logic [4:0] idx,
  output logic [7:0] rom_byte,
  output logic [4:0] last_idx
);

  assign last_idx = 5'(INIT_ROM_LEN - 1);

  always_comb begin
    rom_byte = 8'hE3;
    case (idx)
      5'd0:  rom_byte = 8'hAE;  // display off
      5'd1:  rom_byte = 8'hD5;  // clock divide
      5'd2:  rom_byte = 8'h80;
      5'd3:  rom_byte = 8'hA8;  // multiplex ratio
      5'd4:  rom_byte = 8'h3F;
      5'd5:  rom_byte = 8'hD3;  // display offset
      5'd6:  rom_byte = 8'h00;
      5'd7:  rom_byte = 8'h40;  // start line 0
      5'd8:  rom_byte = 8'h8D;  // charge pump
      5'd9:  rom_byte = 8'h14;
      5'd10: rom_byte = 8'h20;  // addressing mode: page
      5'd11: rom_byte = 8'h02;
      5'd12: rom_byte = 8'hA1;  // segment remap
      5'd13: rom_byte = 8'hC8;  // COM scan reversed
      5'd14: rom_byte = 8'hDA;  // COM pins
      5'd15: rom_byte = 8'h12;
      5'd16: rom_byte = 8'h81;  // contrast
      5'd17: rom_byte = 8'hCF;
      5'd18: rom_byte = 8'hD9;  // precharge
      5'd19: rom_byte = 8'hF1;
      5'd20: rom_byte = 8'hDB;  // VCOMH deselect
      5'd21: rom_byte = 8'h40;
      5'd22: rom_byte = 8'hA4;  // resume from RAM
      5'd23: rom_byte = 8'hA6;  // normal (non-inverted)
      5'd24: rom_byte = 8'hAF;  // display on
      default: rom_byte = 8'hE3;
    endcase
  end

endmodule

// File: rtl/oled_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// oled_cmd_sequencer
// Feeds the OLED I2C byte-write driver one {addr, ctrl, payload} transaction
// at a time: power-up hold-off, SSD1306 init table, optional GDDRAM clear,
// then host command/data pass-through with a valid/ready handshake.
// Ports:
//   clk_50m     in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   reinit      in   1   pulse; restart init from READY or ERROR
//   host_valid  in   1   host byte available
//   host_dc     in   1   0 = command, 1 = GDDRAM data
//   host_byte   in   8   host payload
//   host_ready  out  1   high only in READY
//   init_done   out  1   high from first READY until reset/reinit
//   busy        out  1   high except in READY and ERROR
//   err_timeout out  1   sticky driver-timeout flag
//   iic_slave   out  16  {SLAVE_ADDR, ctrl}, stable request..done
//   iic_wr_req  out  1   one-cycle request pulse
//   iic_wr_data out  8   payload, stable request..done
//   iic_wr_done in   1   one-cycle completion pulse
// ----------------------------------------------------------------------------
module oled_cmd_sequencer
  import oled_pkg::*;
#(
  parameter logic [7:0]  SLAVE_ADDR     = 8'h78,
  parameter int unsigned POWERUP_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter bit          CLEAR_EN       = 1'b1
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        reinit,
  input  logic        host_valid,
  input  logic        host_dc,
  input  logic [7:0]  host_byte,
  output logic        host_ready,
  output logic        init_done,
  output logic        busy,
  output logic        err_timeout,
  output logic [15:0] iic_slave,
  output logic        iic_wr_req,
  output logic [7:0]  iic_wr_data,
  input  logic        iic_wr_done
);

  // One counter serves PWRUP, WAIT and GAP since they never overlap.
  localparam int unsigned CNT_MAX = max3(POWERUP_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  // WAIT counts cycles since the request (1 in the first WAIT cycle), so the
  // flag becomes visible exactly TIMEOUT_CYCLES cycles after iic_wr_req.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] COL_LAST  = 7'(NUM_COLS - 1);
  localparam logic [2:0] PAGE_LAST = 3'(NUM_PAGES - 1);

  seq_state_t       state_q, state_d;
  seq_state_t       origin_q, origin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic [2:0]       page_q, page_d;
  logic [6:0]       col_q, col_d;
  clr_phase_t       phase_q, phase_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic [7:0]       data_q, data_d;
  logic             req_q, req_d;
  logic             host_ready_q, host_ready_d;
  logic             busy_q, busy_d;
  logic             init_done_q, init_done_d;
  logic             err_q, err_d;

  logic [7:0]       rom_byte;
  logic [4:0]       rom_last;

  oled_init_rom u_rom (
    .idx      (idx_q),
    .rom_byte (rom_byte),
    .last_idx (rom_last)
  );

  always_comb begin
    state_d     = state_q;
    origin_d    = origin_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    page_d      = page_q;
    col_d       = col_q;
    phase_d     = phase_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    err_d       = err_q;
    init_done_d = init_done_q;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == '0) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_INIT: begin
        ctrl_d   = CTRL_CMD;
        data_d   = rom_byte;
        origin_d = ST_INIT;
        state_d  = ST_ISSUE;
      end

      ST_CLEAR: begin
        origin_d = ST_CLEAR;
        state_d  = ST_ISSUE;
        case (phase_q)
          CLR_PAGE: begin
            ctrl_d = CTRL_CMD;
            data_d = CMD_PAGE_BASE + {5'd0, page_q};
          end
          CLR_COL_LO: begin
            ctrl_d = CTRL_CMD;
            data_d = CMD_COL_LO;
          end
          CLR_COL_HI: begin
            ctrl_d = CTRL_CMD;
            data_d = CMD_COL_HI;
          end
          default: begin
            ctrl_d = CTRL_DATA;
            data_d = 8'h00;
          end
        endcase
      end

      ST_READY: begin
        // reinit wins over a same-cycle host byte; the byte is not consumed.
        if (reinit) begin
          state_d     = ST_INIT;
          idx_d       = '0;
          err_d       = 1'b0;
          init_done_d = 1'b0;
        end else if (host_valid) begin
          ctrl_d   = host_dc ? CTRL_DATA : CTRL_CMD;
          data_d   = host_byte;
          origin_d = ST_READY;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // done is checked first so a done on the terminal count still succeeds
        if (iic_wr_done) begin
          cnt_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          case (origin_q)
            ST_INIT: begin
              if (idx_q == rom_last) begin
                if (CLEAR_EN) begin
                  state_d = ST_CLEAR;
                  page_d  = '0;
                  col_d   = '0;
                  phase_d = CLR_PAGE;
                end else begin
                  state_d = ST_READY;
                end
              end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_INIT;
              end
            end
            ST_CLEAR: begin
              state_d = ST_CLEAR;
              if (phase_q != CLR_DATA) begin
                phase_d = clr_phase_t'(phase_q + 2'd1);
              end else if (col_q == COL_LAST) begin
                col_d   = '0;
                phase_d = CLR_PAGE;
                if (page_q == PAGE_LAST) state_d = ST_READY;
                else                     page_d  = page_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
            default: state_d = ST_READY;
          endcase
        end
      end

      ST_ERROR: begin
        if (reinit) begin
          state_d     = ST_INIT;
          idx_d       = '0;
          err_d       = 1'b0;
          init_done_d = 1'b0;
        end
      end

      default: state_d = ST_PWRUP;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_d        = (state_d == ST_ISSUE);
    host_ready_d = (state_d == ST_READY);
    busy_d       = (state_d != ST_READY) && (state_d != ST_ERROR);
    if (state_d == ST_READY) init_done_d = 1'b1;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PWRUP;
      origin_q     <= ST_INIT;
      cnt_q        <= PWR_LOAD;
      idx_q        <= '0;
      page_q       <= '0;
      col_q        <= '0;
      phase_q      <= CLR_PAGE;
      ctrl_q       <= CTRL_CMD;
      data_q       <= 8'h00;
      req_q        <= 1'b0;
      host_ready_q <= 1'b0;
      busy_q       <= 1'b1;
      init_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      origin_q     <= origin_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      page_q       <= page_d;
      col_q        <= col_d;
      phase_q      <= phase_d;
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      req_q        <= req_d;
      host_ready_q <= host_ready_d;
      busy_q       <= busy_d;
      init_done_q  <= init_done_d;
      err_q        <= err_d;
    end
  end

  assign iic_slave   = {SLAVE_ADDR, ctrl_q};
  assign iic_wr_data = data_q;
  assign iic_wr_req  = req_q;
  assign host_ready  = host_ready_q;
  assign busy        = busy_q;
  assign init_done   = init_done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_oled_cmd_sequencer
// Scoreboard bench: the reference model pushes every expected driver
// transaction {slave, payload} into a queue; a monitor pops and compares on
// each iic_wr_req. A driver model acks with random latency.
// ----------------------------------------------------------------------------
module tb_oled_cmd_sequencer;

  localparam int unsigned PWR  = 300;
  localparam int unsigned GAPC = 4;
  localparam int unsigned TMO  = 600;
  localparam int          BOOT_TX = 25 + 8 * (3 + 128);

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        reinit;
  logic        host_valid;
  logic        host_dc;
  logic [7:0]  host_byte;
  logic        host_ready;
  logic        init_done;
  logic        busy;
  logic        err_timeout;
  logic [15:0] iic_slave;
  logic        iic_wr_req;
  logic [7:0]  iic_wr_data;
  logic        iic_wr_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int done_cyc = -1;
  int first_req_cyc = -1;
  int last_req_cyc = -1;
  int req_total = 0;
  int rst_gen = 0;
  bit ack_en = 1'b1;
  bit spur_en = 1'b0;
  bit prev_req = 1'b0;
  logic [23:0] exp_q[$];

  oled_cmd_sequencer #(
    .SLAVE_ADDR     (8'h78),
    .POWERUP_CYCLES (PWR),
    .GAP_CYCLES     (GAPC),
    .TIMEOUT_CYCLES (TMO),
    .CLEAR_EN       (1'b1)
  ) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .reinit      (reinit),
    .host_valid  (host_valid),
    .host_dc     (host_dc),
    .host_byte   (host_byte),
    .host_ready  (host_ready),
    .init_done   (init_done),
    .busy        (busy),
    .err_timeout (err_timeout),
    .iic_slave   (iic_slave),
    .iic_wr_req  (iic_wr_req),
    .iic_wr_data (iic_wr_data),
    .iic_wr_done (iic_wr_done)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: full power-on sequence = init table then 8 cleared pages.
  task automatic push_boot();
    logic [7:0] tbl [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
                             8'h40, 8'h8D, 8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8,
                             8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB,
                             8'h40, 8'hA4, 8'hA6, 8'hAF};
    foreach (tbl[i]) exp_q.push_back({16'h7800, tbl[i]});
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back({16'h7800, 8'hB0 + 8'(p)});
      exp_q.push_back({16'h7800, 8'h00});
      exp_q.push_back({16'h7800, 8'h10});
      for (int c = 0; c < 128; c++) exp_q.push_back({16'h7840, 8'h00});
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_host_ready"}, 32'(host_ready), 32'd0);
    check({tag, "_init_done"},  32'(init_done),  32'd0);
    check({tag, "_busy"},       32'(busy),       32'd1);
    check({tag, "_err"},        32'(err_timeout), 32'd0);
    check({tag, "_req"},        32'(iic_wr_req), 32'd0);
    check({tag, "_slave"},      32'(iic_slave),  32'h7800);
    check({tag, "_data"},       32'(iic_wr_data), 32'h00);
  endtask

  task automatic wait_init_done(input string tag, input int base);
    for (int i = 0; i < 30000 && !init_done; i++) @(negedge clk_50m);
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_req_count"}, 32'(req_total - base), 32'(BOOT_TX));
    check({tag, "_ready"}, 32'(host_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic boot_from_reset(input string tag);
    int c0;
    int base;
    @(negedge clk_50m);
    rst_n = 1'b1;
    c0 = cyc;
    first_req_cyc = -1;
    base = req_total;
    push_boot();
    for (int i = 0; i < int'(PWR) + 50 && first_req_cyc < 0; i++) @(negedge clk_50m);
    check({tag, "_first_req_delay"}, 32'(first_req_cyc - c0), 32'(PWR + 1));
    wait_init_done(tag, base);
  endtask

  task automatic send_host(input bit dc, input logic [7:0] b, input bit measure);
    for (int i = 0; i < 5000 && !host_ready; i++) @(negedge clk_50m);
    check("host_ready_wait", 32'(host_ready), 32'd1);
    host_valid = 1'b1;
    host_dc    = dc;
    host_byte  = b;
    done_cyc   = -1;
    exp_q.push_back({8'h78, dc ? 8'h40 : 8'h00, b});
    @(negedge clk_50m);
    host_valid = 1'b0;
    check("host_ready_drop", 32'(host_ready), 32'd0);
    check("host_req_latency", 32'(iic_wr_req), 32'd1);
    if (measure) begin
      for (int i = 0; i < 200 && !host_ready; i++) @(negedge clk_50m);
      check("ready_after_done", 32'(cyc - done_cyc), 32'(GAPC + 1));
    end
  endtask

  task automatic do_reinit(input string tag, input bit with_host);
    reinit = 1'b1;
    if (with_host) begin
      host_valid = 1'b1;
      host_dc    = 1'b1;
      host_byte  = 8'($urandom);
    end
    push_boot();
    @(negedge clk_50m);
    reinit     = 1'b0;
    host_valid = 1'b0;
    check({tag, "_err_clr"},   32'(err_timeout), 32'd0);
    check({tag, "_init_clr"},  32'(init_done),   32'd0);
    check({tag, "_busy"},      32'(busy),        32'd1);
    check({tag, "_ready_low"}, 32'(host_ready),  32'd0);
  endtask

  // Cycle counter and done-pulse timestamp (done sampled as the DUT sees it).
  initial forever begin
    @(posedge clk_50m);
    if (iic_wr_done) done_cyc = cyc;
    cyc = cyc + 1;
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk_50m);
    if (prev_req) check("req_single_cycle", 32'(iic_wr_req), 32'd0);
    if (iic_wr_req) begin
      req_total++;
      last_req_cyc = cyc;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_req: got %h, expected no request", {iic_slave, iic_wr_data});
      end else begin
        check("req_payload", 32'({iic_slave, iic_wr_data}), 32'(exp_q.pop_front()));
      end
    end
    prev_req = iic_wr_req;
  end

  // Driver model
  initial begin
    int gen;
    logic [23:0] cap;
    iic_wr_done = 1'b0;
    forever begin
      @(negedge clk_50m);
      iic_wr_done = 1'b0;
      if (iic_wr_req && ack_en) begin
        gen = rst_gen;
        cap = {iic_slave, iic_wr_data};
        repeat ($urandom_range(1, 6)) @(negedge clk_50m);
        if (gen == rst_gen && rst_n) begin
          check("payload_stable", 32'({iic_slave, iic_wr_data}), 32'(cap));
          iic_wr_done = 1'b1;
          if (spur_en) begin
            @(negedge clk_50m);
            iic_wr_done = 1'b0;
            @(negedge clk_50m);
            iic_wr_done = 1'b1;
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    repeat (98000) @(posedge clk_50m);
    n_fail++;
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n      = 1'b0;
    reinit     = 1'b0;
    host_valid = 1'b0;
    host_dc    = 1'b0;
    host_byte  = 8'h00;
    repeat (3) @(negedge clk_50m);
    check_reset_vals("por");
    boot_from_reset("boot");

    send_host(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 10; i++) send_host(1'($urandom), 8'($urandom), 1'b1);

    // Driver that never answers
    ack_en = 1'b0;
    send_host(1'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < int'(TMO) + 100 && !err_timeout; i++) @(negedge clk_50m);
    check("timeout_delay", 32'(cyc - last_req_cyc), 32'(TMO));
    check("timeout_err", 32'(err_timeout), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_ready", 32'(host_ready), 32'd0);
    ack_en = 1'b1;
    repeat (20) @(negedge clk_50m);
    check("error_sticky", 32'(err_timeout), 32'd1);
    base = req_total;
    do_reinit("reinit_err", 1'b0);
    wait_init_done("reinit_err", base);

    // reinit and host_valid together; stray dones during GAP
    spur_en = 1'b1;
    base = req_total;
    do_reinit("reinit_host", 1'b1);
    wait_init_done("reinit_host", base);
    spur_en = 1'b0;
    send_host(1'b0, 8'($urandom), 1'b1);

    // Reset in the middle of clearing page 5
    for (int i = 0; i < 200 && !host_ready; i++) @(negedge clk_50m);
    base = req_total;
    do_reinit("reinit_clr", 1'b0);
    for (int i = 0; i < 20000 && (req_total - base) < 25 + 5 * 131 + 20; i++)
      @(negedge clk_50m);
    check("reached_page5", 32'((req_total - base) >= 25 + 5 * 131 + 20), 32'd1);
    rst_gen++;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midclr");
    exp_q.delete();
    repeat (3) @(negedge clk_50m);
    check_reset_vals("midclr_hold");
    boot_from_reset("reboot");

    repeat (5) @(negedge clk_50m);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
